// File: rtl/piso_tx_ctrl.sv
// -----------------------------------------------------------------------------
// piso_tx_ctrl
//
// Serial transmit controller built around a parallel-in/serial-out shift
// register. It accepts one N-bit word at a time over a valid/ready handshake.
// Each word is shifted out MSB first, and every bit is held for DIV clocks.
// An optional idle gap of GAP bit periods separates consecutive frames.
//
// Ports:
//   sys_clk    in   system clock, rising-edge active
//   sys_rst_n  in   asynchronous active-low reset
//   in_valid   in   upstream word available
//   in_data    in   upstream word (N bits), sampled only on accept
//   in_ready   out  controller can accept a word (high only in IDLE)
//   sout       out  serial data, MSB first (0 outside SHIFT)
//   sout_en    out  high while a frame bit is on sout
//   busy       out  high whenever the controller is not IDLE
//   done       out  one-cycle pulse after the last bit period of a frame
// -----------------------------------------------------------------------------
module piso_tx_ctrl #(
    parameter int N   = 8,
    parameter int DIV = 4,
    parameter int GAP = 1
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic         sout,
    output logic         sout_en,
    output logic         busy,
    output logic         done
);

    localparam int GAP_CYCLES = GAP * DIV;

    localparam int BIT_W = (N > 1) ? $clog2(N) : 1;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    // A zero-length gap still needs a one-bit counter so that the
    // declaration stays legal. The GAP state is unreachable in that case.
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_reg,   state_next;
    logic [N-1:0]     shreg_reg,   shreg_next;
    logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic             done_reg,    done_next;

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg   <= ST_IDLE;
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shreg_reg   <= shreg_next;
            bit_cnt_reg <= bit_cnt_next;
            div_cnt_reg <= div_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            done_reg    <= done_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        shreg_next   = shreg_reg;
        bit_cnt_next = bit_cnt_reg;
        div_cnt_next = div_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        done_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_next   = in_data;
                    bit_cnt_next = '0;
                    div_cnt_next = '0;
                    state_next   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (div_cnt_reg == DIV_LAST) begin
                    div_cnt_next = '0;
                    if (bit_cnt_reg == BIT_LAST) begin
                        // Last bit period is over. done is registered, so it
                        // rises together with the first GAP/IDLE cycle.
                        done_next    = 1'b1;
                        bit_cnt_next = '0;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt_next = '0;
                            state_next   = ST_GAP;
                        end else begin
                            state_next   = ST_IDLE;
                        end
                    end else begin
                        shreg_next   = {shreg_reg[N-2:0], 1'b0};
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end

            ST_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    gap_cnt_next = '0;
                    state_next   = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of the registered state, so they follow reset
    // immediately without waiting for a clock edge.
    assign in_ready = (state_reg == ST_IDLE);
    assign busy     = ~in_ready;
    assign sout_en  = (state_reg == ST_SHIFT);
    assign sout     = sout_en & shreg_reg[N-1];
    assign done     = done_reg;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_piso_tx_ctrl
//
// Directed bench for piso_tx_ctrl. Instance A uses N=8, DIV=4, GAP=1.
// Instance B uses N=8, DIV=1, GAP=0. Both instances share the clock and reset.
// Every comparison goes through check_value.
// -----------------------------------------------------------------------------
module tb_piso_tx_ctrl;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b1;

    logic       in_valid_a = 1'b0;
    logic [7:0] in_data_a  = 8'h00;
    logic       in_ready_a, sout_a, sout_en_a, busy_a, done_a;

    logic       in_valid_b = 1'b0;
    logic [7:0] in_data_b  = 8'h00;
    logic       in_ready_b, sout_b, sout_en_b, busy_b, done_b;

    int check_count = 0;
    int error_count = 0;
    int cyc         = 0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    piso_tx_ctrl #(.N(8), .DIV(4), .GAP(1)) dut_a (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid_a),
        .in_data   (in_data_a),
        .in_ready  (in_ready_a),
        .sout      (sout_a),
        .sout_en   (sout_en_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    piso_tx_ctrl #(.N(8), .DIV(1), .GAP(0)) dut_b (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid_b),
        .in_data   (in_data_b),
        .in_ready  (in_ready_b),
        .sout      (sout_b),
        .sout_en   (sout_en_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("FAIL %s at t=%0t: observed %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    // The caller is positioned at a negedge. Present the word, wait for
    // in_ready, let the accept edge pass, then apply the post-accept inputs.
    task automatic accept_a(input logic [7:0] word, input logic post_valid,
                            input logic [7:0] post_data, output int acc_cyc);
        int waited = 0;
        in_valid_a = 1'b1;
        in_data_a  = word;
        while (in_ready_a !== 1'b1 && waited < 100) begin
            @(negedge sys_clk);
            waited++;
        end
        check_value("a_accept_wait", 32'(waited < 100), 32'd1);
        @(posedge sys_clk);
        #1;
        acc_cyc    = cyc;
        in_valid_a = post_valid;
        in_data_a  = post_data;
    endtask

    task automatic accept_b(input logic [7:0] word, input logic post_valid,
                            input logic [7:0] post_data, output int acc_cyc);
        int waited = 0;
        in_valid_b = 1'b1;
        in_data_b  = word;
        while (in_ready_b !== 1'b1 && waited < 100) begin
            @(negedge sys_clk);
            waited++;
        end
        check_value("b_accept_wait", 32'(waited < 100), 32'd1);
        @(posedge sys_clk);
        #1;
        acc_cyc    = cyc;
        in_valid_b = post_valid;
        in_data_b  = post_data;
    endtask

    // Check a full DIV=4 frame, the gap that follows it and the return to IDLE.
    // With noise set, in_valid/in_data are disturbed during the frame, and
    // 0x3C is left pending for acceptance once IDLE is reached.
    task automatic frame_check_a(input logic [7:0] word, input bit noise);
        int i;
        for (i = 0; i < 32; i++) begin
            @(negedge sys_clk);
            check_value("a_sout",     32'(sout_a),     32'(word[7 - i/4]));
            check_value("a_sout_en",  32'(sout_en_a),  32'd1);
            check_value("a_busy",     32'(busy_a),     32'd1);
            check_value("a_in_ready", 32'(in_ready_a), 32'd0);
            check_value("a_done",     32'(done_a),     32'd0);
            if (noise) begin
                in_valid_a = ~in_valid_a;
                in_data_a  = 8'h3C;
            end
        end
        @(negedge sys_clk);
        check_value("a_done_pulse",    32'(done_a),     32'd1);
        check_value("a_done_sout_en",  32'(sout_en_a),  32'd0);
        check_value("a_done_sout",     32'(sout_a),     32'd0);
        check_value("a_done_in_ready", 32'(in_ready_a), 32'd0);
        if (noise) begin
            in_valid_a = 1'b1;
            in_data_a  = 8'h3C;
        end
        for (int g = 1; g < 4; g++) begin
            @(negedge sys_clk);
            check_value("a_gap_done",     32'(done_a),     32'd0);
            check_value("a_gap_in_ready", 32'(in_ready_a), 32'd0);
            check_value("a_gap_sout",     32'(sout_a),     32'd0);
            check_value("a_gap_sout_en",  32'(sout_en_a),  32'd0);
        end
        @(negedge sys_clk);
        check_value("a_idle_in_ready", 32'(in_ready_a), 32'd1);
        check_value("a_idle_busy",     32'(busy_a),     32'd0);
        check_value("a_idle_done",     32'(done_a),     32'd0);
        $display("A frame 0x%02h checked, idle at cycle %0d", word, cyc);
    endtask

    // DIV=1, GAP=0 frame: one cycle per bit, then done together with in_ready.
    task automatic frame_check_b(input logic [7:0] word);
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            check_value("b_sout",    32'(sout_b),    32'(word[7 - i]));
            check_value("b_sout_en", 32'(sout_en_b), 32'd1);
            check_value("b_done",    32'(done_b),    32'd0);
        end
        @(negedge sys_clk);
        check_value("b_done_pulse",    32'(done_b),     32'd1);
        check_value("b_done_in_ready", 32'(in_ready_b), 32'd1);
        check_value("b_done_sout_en",  32'(sout_en_b),  32'd0);
        $display("B frame 0x%02h checked at cycle %0d", word, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t1, t2;

        // Reset asserted before the first clock edge
        #1 sys_rst_n = 1'b0;
        #2;
        check_value("rst_in_ready", 32'(in_ready_a), 32'd1);
        check_value("rst_busy",     32'(busy_a),     32'd0);
        check_value("rst_sout",     32'(sout_a),     32'd0);
        check_value("rst_sout_en",  32'(sout_en_a),  32'd0);
        check_value("rst_done",     32'(done_a),     32'd0);
        check_value("rst_b_ready",  32'(in_ready_b), 32'd1);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        $display("reset released at cycle %0d", cyc);

        // 0xA5 single frame
        accept_a(8'hA5, 1'b0, 8'h00, t1);
        $display("A accepted 0xA5 at cycle %0d", t1);
        frame_check_a(8'hA5, 1'b0);
        repeat (2) @(negedge sys_clk);

        // Back-to-back 0xFF then 0x00 with in_valid held high
        accept_a(8'hFF, 1'b1, 8'h00, t1);
        $display("A accepted 0xFF at cycle %0d", t1);
        frame_check_a(8'hFF, 1'b0);
        accept_a(8'h00, 1'b0, 8'h00, t2);
        $display("A accepted 0x00 at cycle %0d", t2);
        check_value("a_b2b_spacing", 32'(t2 - t1), 32'd37);
        frame_check_a(8'h00, 1'b0);
        repeat (2) @(negedge sys_clk);

        // Inputs disturbed while busy with 0xC3
        accept_a(8'hC3, 1'b0, 8'h00, t1);
        $display("A accepted 0xC3 at cycle %0d", t1);
        frame_check_a(8'hC3, 1'b1);
        accept_a(8'h3C, 1'b0, 8'h00, t2);
        $display("A accepted 0x3C at cycle %0d", t2);
        check_value("a_noise_spacing", 32'(t2 - t1), 32'd37);
        frame_check_a(8'h3C, 1'b0);
        repeat (2) @(negedge sys_clk);

        // Reset during bit 3 of 0xF0
        accept_a(8'hF0, 1'b0, 8'h00, t1);
        $display("A accepted 0xF0 at cycle %0d", t1);
        for (int i = 0; i < 13; i++) begin
            @(negedge sys_clk);
            check_value("a_abort_sout", 32'(sout_a), 32'(i < 16));
        end
        #2 sys_rst_n = 1'b0;
        #1;
        check_value("abort_sout",     32'(sout_a),     32'd0);
        check_value("abort_sout_en",  32'(sout_en_a),  32'd0);
        check_value("abort_busy",     32'(busy_a),     32'd0);
        check_value("abort_in_ready", 32'(in_ready_a), 32'd1);
        check_value("abort_done",     32'(done_a),     32'd0);
        $display("reset asserted mid-frame at cycle %0d", cyc);
        repeat (2) begin
            @(negedge sys_clk);
            check_value("abort_hold_done", 32'(done_a), 32'd0);
        end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check_value("abort_rel_ready", 32'(in_ready_a), 32'd1);
        check_value("abort_rel_done",  32'(done_a),     32'd0);
        accept_a(8'h0F, 1'b0, 8'h00, t1);
        $display("A accepted 0x0F at cycle %0d", t1);
        frame_check_a(8'h0F, 1'b0);

        // DIV=1, GAP=0: 0x81, then 0x7E accepted in the done cycle
        accept_b(8'h81, 1'b1, 8'h7E, t1);
        $display("B accepted 0x81 at cycle %0d", t1);
        frame_check_b(8'h81);
        accept_b(8'h7E, 1'b0, 8'h00, t2);
        $display("B accepted 0x7E at cycle %0d", t2);
        check_value("b_spacing", 32'(t2 - t1), 32'd9);
        frame_check_b(8'h7E);
        @(negedge sys_clk);
        check_value("b_end_done",  32'(done_b),     32'd0);
        check_value("b_end_ready", 32'(in_ready_b), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/piso_tx_ctrl.md
Name: piso_tx_ctrl

Overview:
Serial transmit controller that sequences a parallel-in/serial-out shift register. It accepts N-bit words from an upstream producer over a valid/ready handshake and loads each word into an internal shift register. It then shifts the word out MSB first, holding each bit for DIV clocks. An optional idle gap separates consecutive frames. It sits between a parallel data source and a single-wire serial sink.

Parameters:
N, 8, word width in bits; N >= 2
DIV, 4, clocks per serial bit; DIV >= 1
GAP, 1, idle bit periods between frames (each DIV clocks); GAP >= 0

Ports:
sys_clk  input  1  system clock, rising-edge active
sys_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream word available
in_data  input  N  upstream word, sampled only on accept
in_ready  output  1  controller can accept a word; high only in IDLE
sout  output  1  serial data, MSB first
sout_en  output  1  high while a frame bit is on sout
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse after the last bit period of a frame

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is asynchronous and active-low on sys_rst_n. All registers clear immediately when sys_rst_n goes low, independent of sys_clk.
- Values while in reset: state=IDLE, shift register=0, bit_cnt=0, div_cnt=0, gap_cnt=0, done=0. Outputs are sout=0, sout_en=0, busy=0, in_ready=1.
- Output derivation: in_ready = (state==IDLE). busy = !in_ready. sout_en = (state==SHIFT). sout = shreg[N-1] in SHIFT, otherwise 0.
- Accept: occurs at a rising edge where in_valid && in_ready.
  - shreg <= in_data, bit_cnt <= 0, div_cnt <= 0, state <= SHIFT.
  - The MSB appears on sout in the cycle after the accept edge.
- SHIFT state: div_cnt counts 0..DIV-1.
  - At div_cnt==DIV-1 with bit_cnt<N-1: shreg shifts left with 0 fill, bit_cnt increments, div_cnt returns to 0.
  - At div_cnt==DIV-1 with bit_cnt==N-1: the frame ends. done is registered high for the next cycle only. If GAP>0, go to GAP with gap_cnt=0; if GAP==0, go to IDLE.
- Frame length: exactly N*DIV cycles with sout_en=1.
- GAP state:
  - sout=0, sout_en=0, in_ready=0.
  - gap_cnt counts 0..GAP*DIV-1, then the state returns to IDLE.
  - gap_cnt is ceil(log2(GAP*DIV+1)) bits wide.
- Minimum accept-to-accept spacing: 1 + N*DIV + GAP*DIV cycles (the extra 1 is the IDLE accept cycle).
- done timing: done coincides with the first GAP cycle, or with the first IDLE cycle when GAP==0. It never asserts outside a completed frame.
- Inputs while busy: in_valid and in_data are ignored when not in IDLE. No buffering is done. Upstream must hold in_valid until accepted.
- Reset mid-frame: the frame aborts at once. No done pulse is produced. After release, the block is in IDLE with in_ready=1.
- Counter widths: bit_cnt is ceil(log2(N)) bits. div_cnt is max(1, ceil(log2(DIV))) bits. No counter may wrap past its terminal value.

Test Plan:
- Reset: drive sys_rst_n low between clock edges -> all outputs at reset values immediately, in_ready=1 before the next edge.
- N=8, DIV=4, GAP=1, send 0xA5 -> sout = 1,0,1,0,0,1,0,1, each held 4 cycles; sout_en high for exactly 32 cycles; done high 1 cycle right after; in_ready returns 4 cycles after done rises.
- Back-to-back 0xFF then 0x00 with in_valid held high -> second word accepted on the first IDLE cycle; accept-to-accept spacing is exactly 37 cycles; sout 0 throughout the gap.
- While busy with 0xC3, toggle in_valid and change in_data to 0x3C -> sout still 1,1,0,0,0,0,1,1; 0x3C accepted only after IDLE is reached.
- Assert sys_rst_n low during bit 3 of 0xF0 -> sout/sout_en/busy drop at once; no done; after release, a new word 0x0F transmits correctly.
- DIV=1, GAP=0, N=8, send 0x81 -> sout 1,0,0,0,0,0,0,1, one cycle each; done on the next cycle with in_ready=1 in the same cycle.
